// File: rtl/access_pkg.sv
// Shared encodings for the access-entry front end: FSM states, comparator request codes
// and comparator status codes.
package access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQUEST,
    WAIT,
    GRANT,
    DENY,
    LOCKOUT
  } state_e;

  localparam logic [1:0] REQ_IDLE   = 2'b00;
  localparam logic [1:0] REQ_VERIFY = 2'b01;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_DENY  = 2'b10;

endpackage

// File: rtl/access_lock_timer.sv
// Loadable down-counter with enable and zero flag; stops at zero.
// Used for both the verify timeout and the lockout hold-off.
module access_lock_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/access_entry_sequencer.sv
// Keypad-to-comparator sequencer: assembles the password, issues one verify request,
// resolves grant/deny/timeout and enforces a timed lockout after repeated failures.
module access_entry_sequencer
  import access_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT     = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  input  logic                             cancel,
  input  logic [1:0]                       ac_status,
  output logic [1:0]                       ac_request,
  output logic [DIGITS*DIGIT_W-1:0]        ac_data,
  output logic                             ac_data_load,
  output logic                             granted,
  output logic                             denied,
  output logic                             timed_out,
  output logic                             locked,
  output logic                             busy,
  output logic [$clog2(DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

  localparam int DATA_W = DIGITS * DIGIT_W;
  localparam int DCNT_W = $clog2(DIGITS + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);

  state_e              state_q;
  logic [DATA_W-1:0]   buf_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [1:0]          ac_request_q;
  logic                load_q, granted_q, denied_q, timed_out_q, locked_q, busy_q;

  logic                wait_load_d, wait_zero;
  logic                lock_load_d, lock_zero;
  logic [FCNT_W-1:0]   fail_next_d;
  logic                st_grant, st_deny;

  assign st_grant = (ac_status == ST_GRANT);
  assign st_deny  = ac_status[1];  // 11 is reserved and treated as deny

  assign fail_next_d = (fcnt_q == FCNT_W'(MAX_FAIL)) ? fcnt_q : fcnt_q + FCNT_W'(1);
  assign wait_load_d = (state_q == REQUEST);
  assign lock_load_d = (state_q == DENY) && (fail_next_d == FCNT_W'(MAX_FAIL));

  access_lock_timer #(.W(TMO_W)) u_wait_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (wait_load_d),
    .en_i       (state_q == WAIT),
    .load_val_i (TMO_W'(TIMEOUT - 1)),
    .zero_o     (wait_zero)
  );

  access_lock_timer #(.W(LCK_W)) u_lock_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (lock_load_d),
    .en_i       (state_q == LOCKOUT),
    .load_val_i (LCK_W'(LOCK_CYCLES - 1)),
    .zero_o     (lock_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      dcnt_q       <= '0;
      fcnt_q       <= '0;
      ac_request_q <= REQ_IDLE;
      load_q       <= 1'b0;
      granted_q    <= 1'b0;
      denied_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      load_q      <= 1'b0;
      granted_q   <= 1'b0;
      denied_q    <= 1'b0;
      timed_out_q <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          if (cancel) begin
            buf_q   <= '0;
            dcnt_q  <= '0;
            state_q <= IDLE;
          end else if (digit_valid) begin
            buf_q  <= {buf_q[DATA_W-DIGIT_W-1:0], digit_in};
            dcnt_q <= dcnt_q + DCNT_W'(1);
            if (dcnt_q == DCNT_W'(DIGITS - 1)) begin
              state_q      <= REQUEST;
              load_q       <= 1'b1;
              ac_request_q <= REQ_VERIFY;
              busy_q       <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        REQUEST: begin
          dcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A status on the last timeout cycle still wins over the timeout.
          if (st_grant) begin
            state_q      <= GRANT;
            granted_q    <= 1'b1;
            ac_request_q <= REQ_IDLE;
          end else if (st_deny || wait_zero) begin
            state_q      <= DENY;
            denied_q     <= 1'b1;
            timed_out_q  <= !st_deny;
            ac_request_q <= REQ_IDLE;
          end
        end
        GRANT: begin
          fcnt_q  <= '0;
          buf_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DENY: begin
          buf_q  <= '0;
          fcnt_q <= fail_next_d;
          busy_q <= 1'b0;
          if (lock_load_d) begin
            state_q  <= LOCKOUT;
            locked_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCKOUT: begin
          if (lock_zero) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            fcnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ac_request   = ac_request_q;
  assign ac_data      = buf_q;
  assign ac_data_load = load_q;
  assign granted      = granted_q;
  assign denied       = denied_q;
  assign timed_out    = timed_out_q;
  assign locked       = locked_q;
  assign busy         = busy_q;
  assign digit_count  = dcnt_q;
  assign fail_count   = fcnt_q;

endmodule

// File: tb/tb_access_entry_sequencer.sv
// Directed bench for access_entry_sequencer: entry, cancel, timeout, lockout and reset recovery.
module tb_access_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        cancel;
  logic [1:0]  ac_status;
  logic [1:0]  ac_request;
  logic [15:0] ac_data;
  logic        ac_data_load, granted, denied, timed_out, locked, busy;
  logic [2:0]  digit_count;
  logic [1:0]  fail_count;
  logic [31:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  access_entry_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .cancel       (cancel),
    .ac_status    (ac_status),
    .ac_request   (ac_request),
    .ac_data      (ac_data),
    .ac_data_load (ac_data_load),
    .granted      (granted),
    .denied       (denied),
    .timed_out    (timed_out),
    .locked       (locked),
    .busy         (busy),
    .digit_count  (digit_count),
    .fail_count   (fail_count)
  );

  assign all_out = {3'b000, ac_request, ac_data, ac_data_load, granted, denied,
                    timed_out, locked, busy, digit_count, fail_count};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // Leaves the DUT in REQUEST (load strobe visible).
  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) begin
      send_digit(c[15-4*i -: 4]);
    end
  endtask

  // Full failing attempt; ends one cycle after DENY (IDLE or LOCKOUT).
  task automatic deny_attempt(input string tag, input logic [15:0] code, input logic [1:0] st);
    enter_code(code);
    tick();
    ac_status = st;
    tick();
    ac_status = 2'b00;
    chk(tag, {timed_out, denied}, 2'b01);
    tick();
  endtask

  int   lock_len;
  logic ign_bad;
  logic denied_seen;

  initial begin
    digit_in = '0; digit_valid = 1'b0; cancel = 1'b0; ac_status = 2'b00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", all_out, 32'h0);

    // 1: 1,2,3,4 then grant two cycles after load
    enter_code(16'h1234);
    chk("t1_load", ac_data_load, 1);
    chk("t1_data", ac_data, 16'h1234);
    chk("t1_req", ac_request, 2'b01);
    chk("t1_busy", busy, 1);
    send_digit(4'h9);
    chk("t1_load_once", ac_data_load, 0);
    chk("t1_wait_data_hold", ac_data, 16'h1234);
    chk("t1_wait_dcnt", digit_count, 0);
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    chk("t1_granted", {granted, denied}, 2'b10);
    chk("t1_req_idle", ac_request, 2'b00);
    tick();
    chk("t1_grant_pulse", granted, 0);
    chk("t1_fail_cnt", fail_count, 0);
    chk("t1_buf_clear", ac_data, 0);
    chk("t1_not_busy", busy, 0);

    // 2: partial entry, cancel, fresh entry
    send_digit(4'h1);
    send_digit(4'h2);
    chk("t2_dcnt2", digit_count, 2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t2_cancel_dcnt", digit_count, 0);
    chk("t2_cancel_data", ac_data, 0);
    enter_code(16'h5678);
    chk("t2_data", ac_data, 16'h5678);
    chk("t2_load", ac_data_load, 1);
    tick();
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    chk("t2_granted", granted, 1);
    tick();

    // 3: cancel beats a simultaneous digit
    send_digit(4'h3);
    digit_in = 4'h9; digit_valid = 1'b1; cancel = 1'b1;
    tick();
    digit_valid = 1'b0; cancel = 1'b0;
    chk("t3_dcnt", digit_count, 0);
    chk("t3_data", ac_data, 0);

    // 4: timeout after 16 silent WAIT cycles
    enter_code(16'hABCD);
    denied_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      denied_seen |= denied;
    end
    chk("t4_no_early_deny", denied_seen, 0);
    chk("t4_still_waiting", ac_request, 2'b01);
    tick();
    chk("t4_deny_timeout", {denied, timed_out}, 2'b11);
    chk("t4_req_idle", ac_request, 2'b00);
    tick();
    chk("t4_fail_cnt", fail_count, 1);
    chk("t4_pulse_end", {denied, timed_out}, 2'b00);

    // 4b: grant on the final timeout cycle wins
    enter_code(16'h1111);
    for (int i = 0; i < 16; i++) tick();
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    chk("t4b_grant_wins", {granted, denied, timed_out}, 3'b100);
    tick();
    chk("t4b_fail_cleared", fail_count, 0);

    // 5: three denies, lockout of exactly 1000 cycles
    deny_attempt("t5_deny1", 16'h0001, 2'b10);
    chk("t5_fail1", {locked, fail_count}, 3'b001);
    deny_attempt("t5_deny2_reserved", 16'h0002, 2'b11);
    chk("t5_fail2", {locked, fail_count}, 3'b010);
    deny_attempt("t5_deny3", 16'h0003, 2'b10);
    chk("t5_locked", {locked, fail_count}, 3'b111);
    lock_len = 0;
    ign_bad  = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (!locked) break;
      lock_len++;
      if (digit_count != 0 || busy) ign_bad = 1'b1;
      digit_in    = 4'(i);
      digit_valid = 1'b1;
      cancel      = (i % 7 == 0);
      tick();
    end
    digit_valid = 1'b0;
    cancel      = 1'b0;
    chk("t5_lock_len", lock_len, 1000);
    chk("t5_digits_ignored", ign_bad, 0);
    chk("t5_unlocked", locked, 0);
    chk("t5_fail_reset", fail_count, 0);
    chk("t5_dcnt_after", digit_count, 0);
    enter_code(16'h2468);
    chk("t5_retry_data", ac_data, 16'h2468);
    tick();
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    chk("t5_retry_granted", granted, 1);
    tick();

    // 6: reset during WAIT, then a late status
    enter_code(16'h9999);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_wait", all_out, 32'h0);
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    chk("t6_late_status", all_out, 32'h0);
    tick();
    chk("t6_late_status2", all_out, 32'h0);

    // 6b: reset during LOCKOUT
    deny_attempt("t6_deny1", 16'h0101, 2'b10);
    deny_attempt("t6_deny2", 16'h0202, 2'b10);
    deny_attempt("t6_deny3", 16'h0303, 2'b10);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_in_lockout", locked, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_lock", all_out, 32'h0);
    ac_status = 2'b01;
    tick();
    ac_status = 2'b00;
    tick();
    chk("t6_lock_gone", all_out, 32'h0);
    enter_code(16'h1357);
    chk("t6_entry_after_rst", {ac_data_load, ac_data}, {1'b1, 16'h1357});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
